// File: rtl/stage2_pkg.sv
// Shared definitions for the stage-2 family of frame controllers.
package stage2_pkg;

    // Frame sequencing states common to the stage controllers.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default buffer read latency and adder-tree latency.
    localparam int unsigned DEF_RD_LAT  = 1;
    localparam int unsigned DEF_ADD_LAT = 3;

    // Cycles between a read strobe and the matching result write.
    function automatic int unsigned drain_cycles(input int unsigned rd_lat,
                                                 input int unsigned add_lat);
        return rd_lat + add_lat;
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Valid-qualified shift line carrying a strobe and its payload across a fixed latency.
// Payload stages load only when the incoming valid is set, so the output payload
// holds its last qualified value while the output valid is low.
module ctrl_delay_line #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] dat;

    // Shift valids (emptied by clear) and move payloads along with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            dat <= '0;
        end else begin
            vld[0] <= in_valid && !clear;
            if (in_valid && !clear) begin
                dat[0] <= in_data;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1] && !clear;
                if (vld[i-1] && !clear) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/stage2_add_ctrl.sv
// Stage-2 adder controller: sequences partial-sum buffer reads for one frame,
// keeps the adder tree enabled until the last read has drained, and issues
// result writes aligned with valid adder output.
module stage2_add_ctrl
    import stage2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned RD_LAT     = DEF_RD_LAT,
    parameter int unsigned ADD_LAT    = DEF_ADD_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   pix_count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  add_en,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr
);

    localparam int unsigned PIX_W = ADDR_WIDTH + 1;
    // DATA_WIDTH only documents the datapath; it is folded in as zero to keep it referenced.
    localparam int unsigned LAT   = drain_cycles(RD_LAT, ADD_LAT) + 0 * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(LAT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [PIX_W-1:0]   pix_q;
    logic [PIX_W-1:0]   pix_nxt;
    logic [CNT_W-1:0]   drain_cnt;
    logic [CNT_W-1:0]   drain_nxt;
    logic               last_addr_c;

    // Current read is the last of the frame; the all-ones clamp prevents address wrap.
    assign last_addr_c = ((PIX_W'(rd_addr) + PIX_W'(1)) >= pix_q) || (&rd_addr);

    // Next-state, read address, latched length and drain counter.
    always_comb begin
        state_nxt = state;
        addr_nxt  = rd_addr;
        pix_nxt   = pix_q;
        drain_nxt = drain_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    if (pix_count != '0) begin
                        state_nxt = RUN;
                        pix_nxt   = pix_count;
                        addr_nxt  = '0;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (last_addr_c) begin
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end else begin
                    addr_nxt = rd_addr + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == CNT_W'(LAT - 1)) begin
                    state_nxt = DONE;
                end else begin
                    drain_nxt = drain_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Abort wins over everything, including a same-cycle start; addresses hold.
        if (abort) begin
            state_nxt = IDLE;
            addr_nxt  = rd_addr;
            pix_nxt   = pix_q;
            drain_nxt = '0;
        end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_addr   <= '0;
            pix_q     <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            add_en    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_addr   <= addr_nxt;
            pix_q     <= pix_nxt;
            drain_cnt <= drain_nxt;
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
            rd_en     <= (state_nxt == RUN);
            add_en    <= (state_nxt == RUN) || (state_nxt == DRAIN);
        end
    end

    // Read strobe and address delayed to become the result write strobe and address.
    ctrl_delay_line #(
        .DEPTH (LAT),
        .WIDTH (ADDR_WIDTH)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (abort),
        .in_valid  (rd_en),
        .in_data   (rd_addr),
        .out_valid (wr_en),
        .out_data  (wr_addr)
    );

endmodule

// File: doc/stage2_add_ctrl.md
STAGE2_ADD_CTRL -- requirements
Module: stage2_add_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the width of the adder datapath being sequenced; it is informational only and does not affect controller logic.
REQ-002 Parameter ADDR_WIDTH, default 7, is the width of the partial-sum buffer read address and the result buffer write address.
REQ-003 Parameter RD_LAT, default 1, is the buffer read latency in cycles (rd_en to data at adder inputs).
REQ-004 Parameter ADD_LAT, default 3, is the adder-tree latency in cycles (inputs sampled to dataout valid).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle request to process one frame; honoured only in IDLE.
REQ-008 pix_count  in  ADDR_WIDTH+1  number of pixels in the frame; sampled on accepted start.
REQ-009 abort  in  1  synchronous abort; returns the block to IDLE next cycle.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse when the frame completes, not asserted on abort.
REQ-012 rd_en  out  1  read strobe to all six partial-sum buffers.
REQ-013 rd_addr  out  ADDR_WIDTH  common read address for the six buffers.
REQ-014 add_en  out  1  enable to the adder tree; low zeroes its pipeline.
REQ-015 wr_en  out  1  result write strobe, aligned with valid adder dataout.
REQ-016 wr_addr  out  ADDR_WIDTH  result write address.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE: start=1 with pix_count>0 -> RUN, latching pix_count; start=1 with pix_count=0 -> DONE directly, with no rd_en or wr_en.
REQ-019 RUN: rd_en=1 every cycle; rd_addr starts at 0 and increments by 1 per cycle; after the cycle issuing address pix_count-1 -> DRAIN.
REQ-020 DRAIN: lasts exactly RD_LAT+ADD_LAT cycles (4 at defaults), counted by a drain counter; then -> DONE.
REQ-021 DONE: done=1 for one cycle; then -> IDLE.
REQ-022 add_en=1 in RUN and DRAIN, and 0 in IDLE and DONE; it never drops while any issued read is still in flight.
REQ-023 wr_en/wr_addr are rd_en/rd_addr delayed by exactly RD_LAT+ADD_LAT cycles; a read issued in cycle t produces wr_en in cycle t+4 at defaults.
REQ-024 Exactly pix_count wr_en pulses per frame; the last one occurs in the final DRAIN cycle.
REQ-025 start while busy is ignored, with no effect on counters or the latched pix_count.
REQ-026 abort in any state: next cycle state=IDLE, add_en=0, rd_en=0, delay line cleared (no wr_en afterwards), done not pulsed; abort has priority over start in the same cycle.
REQ-027 rd_addr never exceeds pix_count-1; pix_count = 2^ADDR_WIDTH is legal and ends RUN at the all-ones address with no wrap.
REQ-028 rd_addr and wr_addr hold their last value when the corresponding strobe is low.

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, and busy, done, rd_en, add_en and wr_en to 0.
REQ-030 rst_n low asynchronously forces rd_addr, wr_addr, the drain counter, the latched pix_count and all delay-line stages to 0.
REQ-031 Reset asserted mid-frame abandons the frame; after release the block idles until a new start.

Structure
REQ-032 Shared package stage2_pkg holds the FSM state enum and the default RD_LAT/ADD_LAT constants, for reuse by the other stage controllers.
REQ-033 One sub-module, ctrl_delay_line (parameterised depth and width, async active-low reset, sync clear), carries {rd_en, rd_addr} to {wr_en, wr_addr}.

Verification
REQ-034 pix_count=100, start pulse -> rd_addr 0..99 on 100 consecutive cycles, wr_en for addr 0 exactly 4 cycles after its rd_en, 100 wr_en pulses total, done one cycle after the last wr_en, busy low afterwards.
REQ-035 pix_count=0, start -> next cycle DONE with done=1, no rd_en/wr_en/add_en, IDLE the following cycle.
REQ-036 pix_count=5, abort on the 3rd RUN cycle -> IDLE next cycle, add_en=0, zero wr_en after abort, no done pulse.
REQ-037 start re-pulsed during RUN with a different pix_count -> frame length unchanged and only one done pulse.
REQ-038 rst_n asserted in DRAIN -> all outputs 0 immediately (asynchronous); after release start with pix_count=1 -> one read, one write at addr 0, done.
